// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and helpers for the instruction-fetch responder.
// The address checks live here so the RAM port and the fetch path use the same rules.
package imem_fetch_responder_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH  = 32;

  // Canonical addi x0,x0,0 used by the decode stage when it inserts a bubble.
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [INSTR_WIDTH-1:0] data;
    logic                   fault;
  } fetch_rsp_t;

  function automatic logic word_in_range(input logic [ADDR_WIDTH-1:0] addr,
                                         input int unsigned          depth_words);
    return (addr >> 2) < ADDR_WIDTH'(depth_words);
  endfunction

  function automatic logic fetch_fault(input logic [ADDR_WIDTH-1:0] addr,
                                       input int unsigned          depth_words);
    return (addr[1:0] != 2'b00) || !word_in_range(addr, depth_words);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous circular-buffer FIFO with a synchronous clear and a combinational head.
// The head reads as zero whenever the buffer is empty.
module imem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

  // Credit flow control upstream must never let a push land on a full buffer without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst || clear)
                                  !(push && full && !pop))
    else $error("imem_rsp_fifo overflow");

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: fixed-latency reads from an on-chip RAM into a credit-limited
// response buffer, with a redirect flush and a loader write port.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic [ADDR_WIDTH-1:0]  reqAddr,
  input  logic                   flush,
  output logic                   rspValid,
  input  logic                   rspReady,
  output logic [INSTR_WIDTH-1:0] rspData,
  output logic [ADDR_WIDTH-1:0]  rspAddr,
  output logic                   rspFault,
  input  logic                   wrEn,
  input  logic [ADDR_WIDTH-1:0]  wrAddr,
  input  logic [INSTR_WIDTH-1:0] wrData
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [INSTR_WIDTH-1:0] ram [DEPTH_WORDS];
  logic [IW-1:0]          rd_idx;
  logic [IW-1:0]          wr_idx;

  logic                   accept;
  logic                   pop;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            credits_used;
  logic                   fifo_full;
  logic                   fifo_empty;

  fetch_rsp_t             s0_rsp;
  fetch_rsp_t             push_rsp;
  logic                   push_valid;
  fetch_rsp_t             head_rsp;

  assign rd_idx = reqAddr[IW+1:2];
  assign wr_idx = wrAddr[IW+1:2];

  // Credits come from registered counts only, so reqReady never depends on this cycle's pop.
  assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign reqReady     = rst && !flush && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign accept       = reqValid && reqReady;

  // NOTE: the write is non-blocking, so a fetch in the same cycle still sees the old word.
  always_ff @(posedge clk) begin
    if (rst && wrEn && word_in_range(wrAddr, DEPTH_WORDS)) ram[wr_idx] <= wrData;
  end

  always_comb begin
    s0_rsp       = '0;
    s0_rsp.addr  = reqAddr;
    s0_rsp.fault = fetch_fault(reqAddr, DEPTH_WORDS);
    s0_rsp.data  = s0_rsp.fault ? '0 : ram[rd_idx];
  end

  // The response buffer itself is the final latency stage, so LATENCY-1 registers sit in front.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_valid = accept;
      assign push_rsp   = s0_rsp;
    end else begin : g_pipe
      logic [LATENCY-2:0] v_q;
      fetch_rsp_t         rsp_q [LATENCY-1];

      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          v_q <= '0;
        end else begin
          v_q[0] <= accept;
          for (int k = 1; k < LATENCY-1; k++) v_q[k] <= v_q[k-1];
        end
      end

      // Payload registers follow their valid bit and need no reset.
      always_ff @(posedge clk) begin
        rsp_q[0] <= s0_rsp;
        for (int k = 1; k < LATENCY-1; k++) rsp_q[k] <= rsp_q[k-1];
      end

      assign push_valid = v_q[LATENCY-2];
      assign push_rsp   = rsp_q[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      inflight <= '0;
    end else begin
      case ({accept, push_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  imem_rsp_fifo #(
    .WIDTH ($bits(fetch_rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push_valid),
    .push_data (push_rsp),
    .pop       (pop),
    .head_data (head_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rspValid = rst && !fifo_empty;
  assign pop      = rspValid && rspReady;
  assign rspData  = rspValid ? head_rsp.data  : '0;
  assign rspAddr  = rspValid ? head_rsp.addr  : '0;
  assign rspFault = rspValid ? head_rsp.fault : 1'b0;

  // A full buffer has consumed every credit, so nothing can still be in the pipeline.
  a_full_no_inflight: assert property (@(posedge clk) disable iff (!rst || flush)
                                       fifo_full |-> (inflight == '0))
    else $error("response buffer full with fetches still in flight");

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_imem_fetch_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int FD    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [31:0] reqAddr = '0;
  logic        flush = 1'b0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspData;
  logic [31:0] rspAddr;
  logic        rspFault;
  logic        wrEn = 1'b0;
  logic [31:0] wrAddr = '0;
  logic [31:0] wrData = '0;

  imem_fetch_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqAddr  (reqAddr),
    .flush    (flush),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspData  (rspData),
    .rspAddr  (rspAddr),
    .rspFault (rspFault),
    .wrEn     (wrEn),
    .wrAddr   (wrAddr),
    .wrData   (wrData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    int          ready_cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mram [DEPTH];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          dut_acc  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit          vis;
    bit          exp_ready;
    bit          acc;
    bit          pop;
    exp_t        e;
    logic [31:0] a;
    @(negedge clk);
    vis       = (q.size() > 0) && (q[0].ready_cyc <= cyc);
    exp_ready = rst && !flush && (q.size() < FD);
    check("reqReady", reqReady, exp_ready);
    check("rspValid", rspValid, rst && vis);
    if (rst && vis) begin
      check("rspData",  rspData,  q[0].data);
      check("rspAddr",  rspAddr,  q[0].addr);
      check("rspFault", rspFault, q[0].fault);
    end else if (!vis) begin
      check("rspData_empty",  rspData,  32'h0);
      check("rspAddr_empty",  rspAddr,  32'h0);
      check("rspFault_empty", rspFault, 32'h0);
    end
    if (reqValid && reqReady) dut_acc++;
    acc = reqValid && exp_ready;
    pop = rst && vis && rspReady && !flush;
    @(posedge clk);
    if (!rst || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        a           = reqAddr;
        e.addr      = a;
        e.fault     = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
        e.data      = 32'h0;
        if (!e.fault) e.data = mram[a >> 2];
        e.ready_cyc = cyc + LAT;
        q.push_back(e);
      end
    end
    if (rst && wrEn && ((wrAddr >> 2) < 32'(DEPTH))) mram[wrAddr >> 2] = wrData;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    reqValid = 1'b0;
    wrEn     = 1'b0;
    flush    = 1'b0;
    rspReady = 1'b1;
    repeat (n) tick();
  endtask

  task automatic req(input logic [31:0] a);
    reqValid = 1'b1;
    reqAddr  = a;
    tick();
  endtask

  initial begin
    int a0;

    // Reset state
    repeat (2) tick();
    rst = 1'b1;

    // Load the whole RAM so every in-range fetch has defined data
    for (int i = 0; i < DEPTH; i++) begin
      wrEn   = 1'b1;
      wrAddr = 32'(i) << 2;
      wrData = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom;
      tick();
    end
    wrEn = 1'b0;

    // Back-to-back fetches 0,4,8
    rspReady = 1'b1;
    req(32'h0);
    req(32'h4);
    check("b2b_T2_data", rspData, 32'h1000_0000);
    req(32'h8);
    check("b2b_T3_data", rspData, 32'h1000_0001);
    reqValid = 1'b0;
    tick();
    check("b2b_T4_data", rspData, 32'h1000_0002);
    check("b2b_T4_addr", rspAddr, 32'h8);
    idle(4);

    // Credit exhaustion with the consumer stalled
    rspReady = 1'b0;
    a0 = dut_acc;
    for (int i = 0; i < 8; i++) req(32'(i) << 2);
    check("credit_accepts", 32'(dut_acc - a0), 32'd4);
    reqValid = 1'b0;
    #1;
    check("credit_ready_low", reqReady, 1'b0);
    rspReady = 1'b1;
    #1;
    check("credit_pop_same_cycle", reqReady, 1'b0);
    tick();
    rspReady = 1'b0;
    #1;
    check("credit_pop_next_cycle", reqReady, 1'b1);
    idle(8);

    // Faulting addresses between good neighbours
    req(32'h10);
    req(32'h2);
    req(32'h400);
    req(32'h14);
    idle(6);

    // Same-cycle write and fetch to one word, then the new word
    wrEn   = 1'b1;
    wrAddr = 32'h80;
    wrData = 32'hDEAD_BEEF;
    req(32'h80);
    wrEn = 1'b0;
    req(32'h80);
    idle(6);

    // Flush with a full pipeline and buffer
    rspReady = 1'b0;
    for (int i = 0; i < 6; i++) req(32'(i) << 2);
    flush = 1'b1;
    a0    = dut_acc;
    req(32'h1C);
    check("flush_no_accept", 32'(dut_acc - a0), 32'd0);
    flush    = 1'b0;
    reqValid = 1'b0;
    #1;
    check("flush_rsp_valid_after", rspValid, 1'b0);
    rspReady = 1'b1;
    req(32'h4);
    reqValid = 1'b0;
    tick();
    check("flush_new_data", rspData, 32'h1000_0001);
    tick();
    check("flush_only_one", rspValid, 1'b0);
    idle(4);

    // Mid-operation reset with three buffered responses
    rspReady = 1'b0;
    req(32'h0);
    req(32'h4);
    req(32'h8);
    reqValid = 1'b0;
    repeat (3) tick();
    check("rst_buffered", rspValid, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_rsp_valid", rspValid, 1'b0);
    check("rst_req_ready", reqReady, 1'b0);
    tick();
    rst = 1'b1;
    idle(2);
    req(32'hC);
    reqValid = 1'b0;
    tick();
    check("rst_ram_kept", rspData, 32'h1000_0003);
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reqValid = $urandom_range(3) != 0;
      case ($urandom_range(9))
        0:       reqAddr = $urandom;
        1:       reqAddr = (32'($urandom_range(DEPTH-1)) << 2) | 32'($urandom_range(3, 1));
        default: reqAddr = 32'($urandom_range(DEPTH-1)) << 2;
      endcase
      rspReady = $urandom_range(2) != 0;
      flush    = $urandom_range(31) == 0;
      rst      = $urandom_range(99) != 0;
      wrEn     = $urandom_range(3) == 0;
      wrAddr   = ($urandom_range(4) == 0) ? 32'h400 + 32'($urandom_range(1023))
                                          : 32'($urandom_range(4*DEPTH-1));
      wrData   = $urandom;
      tick();
    end
    rst = 1'b1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Responder end of the instruction-fetch interface. Accepts fetch requests carrying a byte address from the PC stage and returns the addressed instruction word from an on-chip instruction RAM. Response latency is fixed and the block buffers responses internally. A redirect can discard all outstanding fetches, and backpressure is credit-based in both directions. It sits between the PC register and the IF/ID pipeline register; a loader port fills the RAM.

Parameters:
DEPTH_WORDS, 256, instruction RAM depth in 32-bit words (power of 2, >=2)
LATENCY, 2, registered cycles from request acceptance to rspValid (>=1)
FIFO_DEPTH, 4, response buffer entries and maximum outstanding requests (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset; sampled at clk rising edge, low = reset
reqValid  input  1  fetch request present
reqReady  output  1  request can be accepted this cycle
reqAddr  input  32  byte address of instruction
flush  input  1  redirect: discard all in-flight and buffered fetches
rspValid  output  1  response at FIFO head
rspReady  input  1  consumer takes head this cycle
rspData  output  32  instruction word (0 when rspFault)
rspAddr  output  32  reqAddr that produced this response
rspFault  output  1  reqAddr[1:0]!=0 or word index >= DEPTH_WORDS
wrEn  input  1  loader write strobe
wrAddr  input  32  loader byte address (bits [1:0] ignored)
wrData  input  32  loader word

Behaviour:
- Accept = reqValid && reqReady. Pop = rspValid && rspReady. Both take effect at the clock edge.
- reqReady = rst && !flush && (inflight + fifoCount) < FIFO_DEPTH. It uses registered counts only, so there is no combinational path from rspReady or reqValid to reqReady. A pop frees a credit from the next cycle.
- RAM read uses word index reqAddr[log2(DEPTH_WORDS)+1:2] and is sampled in the accept cycle.
- A write (wrEn) in the same cycle to the same word: the fetch returns the OLD data. The new data is visible from the next cycle.
- Out-of-range writes are dropped.
- Fault: a misaligned or out-of-range address is still accepted and consumes a credit. It returns rspFault=1 and rspData=0, and its RAM read is suppressed.
- Pipeline: LATENCY valid/addr/data/fault stages, with the last stage writing the FIFO. A request accepted in cycle T gives rspValid=1 in cycle T+LATENCY when the FIFO was empty. In-order delivery is required.
- FIFO: circular buffer. Head drives rspData/rspAddr/rspFault combinationally, and these are held stable while rspValid && !rspReady.
- Simultaneous push and pop on a full FIFO is legal. Overflow cannot occur by construction; an assertion checks it.
- Pointers wrap modulo FIFO_DEPTH.
- inflight counter: +1 on accept, -1 when the last stage pushes.
- flush (priority over everything except rst):
  - clears all pipeline valids, FIFO pointers, count and inflight at that edge;
  - reqReady is 0 in the flush cycle, so no request is accepted;
  - a pop in the flush cycle is ignored;
  - rspValid is 0 in the cycle after flush.
- Reset (rst=0 at edge, including mid-operation):
  - pipeline valids, FIFO pointers, count and inflight all go to 0;
  - outputs: rspValid=0, reqReady=0 while rst=0; rspData, rspAddr and rspFault are 0 when empty;
  - RAM contents are not reset;
  - loader writes are ignored while rst=0.
- Width rules: counts are log2(FIFO_DEPTH)+1 bits; all address compares are unsigned 32-bit.

Decomposition:
- Shared package holds:
  - INSTR_WIDTH=32 and ADDR_WIDTH=32;
  - NOP_INSTR=32'h00000013 for downstream bubble insertion;
  - a fetch-response struct {addr, data, fault}.
- One sub-module: imem_rsp_fifo. It is a parameterised synchronous FIFO with push/pop, full/empty and count, and the same rst semantics.
- The RAM array and pipeline stay in the top module.

Test Plan:
- Loader writes words 0..7 with 32'h1000_0000+i, then reqAddr=0,4,8 back-to-back with rspReady=1 -> rspData 10000000, 10000001, 10000002 in cycles T+2, T+3, T+4, with rspAddr matching.
- rspReady=0, stream requests -> exactly 4 accepted, reqReady=0 afterwards. Then one pop -> reqReady=1 the following cycle, not the same cycle.
- reqAddr=32'h2 and reqAddr=32'h400 (DEPTH=256) -> both rspFault=1, rspData=0, order preserved relative to neighbours.
- Fill pipeline and FIFO, assert flush for 1 cycle together with reqValid -> no accept that cycle, rspValid=0 next cycle. A new request to addr 4 then returns 10000001 only.
- Pull rst low for one edge with 3 responses buffered -> rspValid=0, reqReady=0 during reset. After release, RAM still returns 10000003 for addr 12.
